fpm_arbiter: RTL and testbench
==============================

FPM_ARBITER -- requirements
Module: fpm_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: result-wait watchdog limit in cycles; only used when FPM_ARB_TIMEOUT_EN is defined; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operand pair.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  32 each  IEEE-754 single operands.
REQ-006 req0_ready, req1_ready  output  1 each  pair accepted when valid and ready are both high.
REQ-007 rsp0_valid, rsp1_valid  output  1 each  result available to requester N.
REQ-008 rsp0_data, rsp1_data  output  32 each  product.
REQ-009 rsp0_err, rsp1_err  output  1 each  watchdog error flag, qualified by rspN_valid.
REQ-010 rsp0_ready, rsp1_ready  input  1 each  requester N consumes the response.
REQ-011 fpm_number_in  output  32  shared operand bus to the multiplier.
REQ-012 fpm_a_valid, fpm_b_valid  output  1 each  operand A or B valid on fpm_number_in.
REQ-013 fpm_a_ready, fpm_b_ready  input  1 each  multiplier accepts operand A or B.
REQ-014 fpm_result  input  32  multiplier product.
REQ-015 fpm_result_valid  input  1  single-cycle pulse marking fpm_result; no backpressure.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, WAIT_RES and RESP.
REQ-018 In IDLE, the block SHALL grant reqN_ready combinationally to exactly one valid requester: round-robin, preferring the requester not served last.
REQ-019 On handshake in IDLE, the block SHALL capture a, b and the grant index, then go to LOAD_A on the next cycle.
REQ-020 In LOAD_A, the block SHALL drive fpm_number_in = a_reg and fpm_a_valid = 1; on fpm_a_ready it SHALL go to LOAD_B.
REQ-021 In LOAD_B, the block SHALL drive fpm_number_in = b_reg and fpm_b_valid = 1; on fpm_b_ready it SHALL go to WAIT_RES.
REQ-022 In WAIT_RES, on fpm_result_valid the block SHALL register fpm_result and go to RESP.
REQ-023 fpm_result_valid SHALL be ignored in every state other than WAIT_RES.
REQ-024 In RESP, the block SHALL hold rspN_valid for the granted N only, with data stable; on rspN_ready it SHALL return to IDLE and record N as last served.
REQ-025 A response stalled in RESP SHALL block new grants; reqN_ready SHALL be low in all states except IDLE.
REQ-026 fpm_number_in SHALL be 0 in IDLE, WAIT_RES and RESP; both fpm_*_valid outputs SHALL be low outside their load state.
REQ-027 Minimum latency with always-ready multiplier inputs: accept at cycle 0, A at cycle 1, B at cycle 2, rsp_valid one cycle after the fpm_result_valid pulse.
REQ-028 Both requesters valid at the same time: only the round-robin winner SHALL see ready; the loser SHALL be served next, provided it is still valid.
REQ-029 rspN_data and rspN_err SHALL be 0 when rspN_valid is low.

Reset
REQ-030 While rst = 0, the block SHALL force IDLE, the last-served pointer = 1 (so req0 wins the first tie), all outputs to 0 and the operand/result registers to 0.
REQ-031 Reset asserted mid-operation SHALL abort the transaction with no response; a result pulse arriving after reset release SHALL be ignored.

Configuration
REQ-032 With FPM_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_RES; after TIMEOUT_CYCLES cycles without fpm_result_valid, the block SHALL enter RESP with data 0x7FC00000 and rspN_err = 1.
REQ-033 Without FPM_ARB_TIMEOUT_EN, no counter SHALL exist, WAIT_RES SHALL wait indefinitely and rsp0_err/rsp1_err SHALL be tied 0.

Verification
REQ-034 Single request: req0 a = 0xBF9149FE, b = 0xBFE18961; stub multiplier returns 0x40000000 three cycles after B -> rsp0_valid with 0x40000000, rsp0_err = 0, rsp1_valid never high.
REQ-035 Tie after reset: both requesters valid at the same time -> req0 served first, then req1; a second tie with req0 last served -> req1 served first.
REQ-036 Backpressure: fpm_a_ready held low 4 cycles and rsp1_ready held low 5 cycles -> fpm_number_in stable during the stall, rsp1_data stable, no new grant until consumed.
REQ-037 Spurious fpm_result_valid pulse in LOAD_B -> ignored; the later pulse with 0x3F800000 is returned.
REQ-038 rst pulsed low during WAIT_RES -> all outputs 0 immediately, a subsequent result pulse is ignored, and busy stays 0.
REQ-039 With FPM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no result pulse -> rsp valid with 0x7FC00000 and err = 1; without the macro, busy stays high.

Source files
------------

// File: rtl/fpm_arbiter.sv
// fpm_arbiter: round-robin front end sharing one operand-serial FP multiplier between two requesters.
// Optional result watchdog is compiled in when FPM_ARB_TIMEOUT_EN is defined.
module fpm_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp0_data,
    output logic [31:0] rsp1_data,
    output logic        rsp0_err,
    output logic        rsp1_err,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] fpm_number_in,
    output logic        fpm_a_valid,
    output logic        fpm_b_valid,
    input  logic        fpm_a_ready,
    input  logic        fpm_b_ready,
    input  logic [31:0] fpm_result,
    input  logic        fpm_result_valid,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT_RES, RESP} state_t;

    state_t      state, state_nxt;
    logic        grant_idx, last_served;
    logic [31:0] a_reg, b_reg, res_reg;
    logic        err_flag;
    logic        grant0, grant1, accept, rsp_ready_sel, result_take, timeout_hit;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    // Ties go to the requester not served last; ready is held low while reset is asserted.
    assign grant0        = (state == IDLE) && rst && req0_valid && (!req1_valid || last_served);
    assign grant1        = (state == IDLE) && rst && req1_valid && (!req0_valid || !last_served);
    assign accept        = grant0 | grant1;
    assign rsp_ready_sel = grant_idx ? rsp1_ready : rsp0_ready;
    assign result_take   = (state == WAIT_RES) && fpm_result_valid;

`ifdef FPM_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign timeout_hit = (state == WAIT_RES) && !fpm_result_valid &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   wait_cnt <= '0;
        else if (state == WAIT_RES) wait_cnt <= wait_cnt + 16'd1;
        else                        wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             err_flag <= 1'b0;
        else if (result_take) err_flag <= 1'b0;
        else if (timeout_hit) err_flag <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign err_flag    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: the default assignment comes first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept)                     state_nxt = LOAD_A;
            LOAD_A:   if (fpm_a_ready)                state_nxt = LOAD_B;
            LOAD_B:   if (fpm_b_ready)                state_nxt = WAIT_RES;
            WAIT_RES: if (result_take || timeout_hit) state_nxt = RESP;
            RESP:     if (rsp_ready_sel)              state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready    = grant0;
        req1_ready    = grant1;
        busy          = (state != IDLE);
        fpm_number_in = '0;
        fpm_a_valid   = 1'b0;
        fpm_b_valid   = 1'b0;
        rsp0_valid    = 1'b0;
        rsp1_valid    = 1'b0;
        rsp0_data     = '0;
        rsp1_data     = '0;
        rsp0_err      = 1'b0;
        rsp1_err      = 1'b0;
        case (state)
            LOAD_A: begin
                fpm_number_in = a_reg;
                fpm_a_valid   = 1'b1;
            end
            LOAD_B: begin
                fpm_number_in = b_reg;
                fpm_b_valid   = 1'b1;
            end
            RESP: begin
                if (grant_idx) begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = res_reg;
                    rsp1_err   = err_flag;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = res_reg;
                    rsp0_err   = err_flag;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            grant_idx   <= 1'b0;
            last_served <= 1'b1;
        end else begin
            if (accept) begin
                a_reg     <= grant1 ? req1_a : req0_a;
                b_reg     <= grant1 ? req1_b : req0_b;
                grant_idx <= grant1;
            end
            if (state == RESP && rsp_ready_sel) last_served <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             res_reg <= '0;
        else if (result_take) res_reg <= fpm_result;
        else if (timeout_hit) res_reg <= 32'h7FC0_0000;
    end

endmodule

// File: tb/tb_fpm_arbiter.sv
// tb_fpm_arbiter: table-driven transactions, hand-written corner sequences and a randomized
// run against a transaction-level model of the arbiter (FPM_ARB_TIMEOUT_EN selects watchdog checks).
module tb_fpm_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] fpm_number_in;
    logic        fpm_a_valid, fpm_b_valid;
    logic        fpm_a_ready, fpm_b_ready;
    logic [31:0] fpm_result;
    logic        fpm_result_valid;
    logic        busy;

    fpm_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .fpm_number_in(fpm_number_in),
        .fpm_a_valid(fpm_a_valid), .fpm_b_valid(fpm_b_valid),
        .fpm_a_ready(fpm_a_ready), .fpm_b_ready(fpm_b_ready),
        .fpm_result(fpm_result), .fpm_result_valid(fpm_result_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        fpm_a_ready = 1'b1; fpm_b_ready = 1'b1;
        fpm_result = '0; fpm_result_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0, a1, b1;
        logic [31:0] result;
        int          delay;      // result pulse comes this many cycles after the B cycle
        logic        exp_owner;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp_a, exp_b;
        exp_a = v.exp_owner ? v.a1 : v.a0;
        exp_b = v.exp_owner ? v.b1 : v.b0;
        next_cycle();
        req0_valid = v.v0; req1_valid = v.v1;
        req0_a = v.a0; req0_b = v.b0; req1_a = v.a1; req1_b = v.b1;
        sample();
        check($sformatf("v%0d_grant", idx), 32'({req0_ready, req1_ready}),
              v.exp_owner ? 32'd1 : 32'd2);
        check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        check($sformatf("v%0d_a_flags", idx), 32'({fpm_a_valid, fpm_b_valid, busy}), 32'b101);
        check($sformatf("v%0d_a_bus", idx), fpm_number_in, exp_a);
        next_cycle();
        sample();
        check($sformatf("v%0d_b_flags", idx), 32'({fpm_a_valid, fpm_b_valid, busy}), 32'b011);
        check($sformatf("v%0d_b_bus", idx), fpm_number_in, exp_b);
        for (int c = 1; c <= v.delay; c++) begin
            next_cycle();
            if (c == v.delay) begin
                fpm_result_valid = 1'b1;
                fpm_result       = v.result;
            end
            sample();
            check($sformatf("v%0d_wait_flags", idx),
                  32'({fpm_a_valid, fpm_b_valid, rsp0_valid, rsp1_valid, busy}), 32'b00001);
            check($sformatf("v%0d_wait_bus", idx), fpm_number_in, 32'd0);
        end
        next_cycle();
        fpm_result_valid = 1'b0; fpm_result = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        sample();
        check($sformatf("v%0d_rsp_valid", idx), 32'({rsp0_valid, rsp1_valid}),
              v.exp_owner ? 32'd1 : 32'd2);
        check($sformatf("v%0d_rsp0_data", idx), rsp0_data, v.exp_owner ? 32'd0 : v.result);
        check($sformatf("v%0d_rsp1_data", idx), rsp1_data, v.exp_owner ? v.result : 32'd0);
        check($sformatf("v%0d_rsp_err", idx), 32'({rsp0_err, rsp1_err}), 32'd0);
        next_cycle();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        sample();
        check($sformatf("v%0d_done", idx), 32'({busy, rsp0_valid, rsp1_valid}), 32'd0);
    endtask

    // Transaction-level model state for the randomized run.
    bit          m_active, m_owner, m_a_sent, m_b_sent, m_have_res, m_err, m_last;
    logic [31:0] m_a, m_b, m_res;
    int          m_waited;

    task automatic random_run(input int cycles);
        bit          any_req, winner, g0, g1;
        logic [31:0] exp_bus;
        m_active = 0; m_last = 1; m_have_res = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            next_cycle();
            req0_valid       = ($urandom_range(0, 99) < 55);
            req1_valid       = ($urandom_range(0, 99) < 55);
            req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
            fpm_a_ready      = ($urandom_range(0, 3) != 0);
            fpm_b_ready      = ($urandom_range(0, 3) != 0);
            fpm_result_valid = ($urandom_range(0, 3) == 0);
            fpm_result       = $urandom;
            rsp0_ready       = ($urandom_range(0, 2) != 0);
            rsp1_ready       = ($urandom_range(0, 2) != 0);
            sample();

            any_req = req0_valid | req1_valid;
            if (req0_valid && req1_valid) winner = ~m_last;
            else                          winner = req1_valid;
            g0 = !m_active && any_req && (winner == 1'b0);
            g1 = !m_active && any_req && (winner == 1'b1);
            if (m_active && !m_a_sent)      exp_bus = m_a;
            else if (m_active && !m_b_sent) exp_bus = m_b;
            else                            exp_bus = '0;

            check("rnd_ready", 32'({req0_ready, req1_ready}), 32'({g0, g1}));
            check("rnd_fpm_flags", 32'({fpm_a_valid, fpm_b_valid, busy}),
                  32'({m_active && !m_a_sent, m_active && m_a_sent && !m_b_sent, m_active}));
            check("rnd_fpm_bus", fpm_number_in, exp_bus);
            check("rnd_rsp_flags", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}),
                  32'({m_have_res && !m_owner, m_have_res && m_owner,
                       m_have_res && !m_owner && m_err, m_have_res && m_owner && m_err}));
            check("rnd_rsp0_data", rsp0_data, (m_have_res && !m_owner) ? m_res : 32'd0);
            check("rnd_rsp1_data", rsp1_data, (m_have_res && m_owner) ? m_res : 32'd0);

            if (!m_active) begin
                if (any_req) begin
                    m_active = 1; m_owner = winner;
                    m_a = winner ? req1_a : req0_a;
                    m_b = winner ? req1_b : req0_b;
                    m_a_sent = 0; m_b_sent = 0; m_have_res = 0; m_waited = 0;
                end
            end else if (!m_a_sent) begin
                m_a_sent = fpm_a_ready;
            end else if (!m_b_sent) begin
                m_b_sent = fpm_b_ready;
            end else if (!m_have_res) begin
                if (fpm_result_valid) begin
                    m_have_res = 1; m_res = fpm_result; m_err = 0;
                end else begin
                    m_waited++;
`ifdef FPM_ARB_TIMEOUT_EN
                    if (m_waited == TO) begin
                        m_have_res = 1; m_res = 32'h7FC0_0000; m_err = 1;
                    end
`endif
                end
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_active = 0; m_have_res = 0; m_last = m_owner;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{v0:1, v1:1, a0:32'h3F800000, b0:32'h40000000, a1:32'h40400000, b1:32'h40800000,
                    result:32'h40000000, delay:2, exp_owner:0};
        vecs[1] = '{v0:1, v1:1, a0:32'h11111111, b0:32'h22222222, a1:32'h33333333, b1:32'h44444444,
                    result:32'h12345678, delay:1, exp_owner:1};
        vecs[2] = '{v0:1, v1:0, a0:32'hBF9149FE, b0:32'hBFE18961, a1:32'h55555555, b1:32'h66666666,
                    result:32'h40000000, delay:3, exp_owner:0};
        vecs[3] = '{v0:1, v1:1, a0:32'hAAAA0000, b0:32'h0000AAAA, a1:32'hBBBB0000, b1:32'h0000BBBB,
                    result:32'hC1200000, delay:4, exp_owner:1};
        vecs[4] = '{v0:0, v1:1, a0:32'h01010101, b0:32'h02020202, a1:32'h40490FDB, b1:32'h402DF854,
                    result:32'h41089A1E, delay:2, exp_owner:1};
        vecs[5] = '{v0:1, v1:1, a0:32'h7F7FFFFF, b0:32'h00800000, a1:32'hFF800000, b1:32'h80000000,
                    result:32'h3FFFFFFF, delay:1, exp_owner:0};

        // Reset state, with requests already pending.
        clear_inputs();
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        sample();
        check("rst_flags", 32'({req0_ready, req1_ready, busy, fpm_a_valid, fpm_b_valid,
                               rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
        check("rst_bus", fpm_number_in, 32'd0);
        check("rst_rsp_data", rsp0_data | rsp1_data, 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Operand stall of 4 cycles, then response stall of 5 cycles with req0 waiting.
        do_reset();
        next_cycle();
        req1_valid = 1'b1; req1_a = 32'h41200000; req1_b = 32'h41300000; fpm_a_ready = 1'b0;
        sample();
        check("bp_grant", 32'({req0_ready, req1_ready}), 32'd1);
        next_cycle();
        req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 32'h3F000000; req0_b = 32'h3E800000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            sample();
            check("bp_a_stall_bus", fpm_number_in, 32'h41200000);
            check("bp_a_stall_flags", 32'({fpm_a_valid, fpm_b_valid, req0_ready}), 32'b100);
        end
        next_cycle();
        fpm_a_ready = 1'b1;
        sample();
        check("bp_a_release", 32'({fpm_a_valid, fpm_b_valid}), 32'b10);
        next_cycle();
        sample();
        check("bp_b_bus", fpm_number_in, 32'h41300000);
        next_cycle();
        fpm_result_valid = 1'b1; fpm_result = 32'h42DC0000;
        sample();
        check("bp_wait_rsp", 32'({rsp1_valid, req0_ready}), 32'd0);
        next_cycle();
        fpm_result_valid = 1'b0; fpm_result = '0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            sample();
            check("bp_rsp_stall_flags", 32'({rsp1_valid, rsp0_valid, req0_ready, busy}), 32'b1001);
            check("bp_rsp_stall_data", rsp1_data, 32'h42DC0000);
        end
        next_cycle();
        rsp1_ready = 1'b1;
        sample();
        check("bp_consume", rsp1_data, 32'h42DC0000);
        next_cycle();
        rsp1_ready = 1'b0;
        sample();
        check("bp_next_grant", 32'({req0_ready, req1_ready, busy}), 32'b100);

        // Spurious result pulse during LOAD_B.
        do_reset();
        next_cycle();
        req0_valid = 1'b1; req0_a = 32'h40A00000; req0_b = 32'h3E4CCCCD;
        sample();
        check("sp_grant", 32'({req0_ready, req1_ready}), 32'd2);
        next_cycle();
        req0_valid = 1'b0; fpm_b_ready = 1'b0;
        sample();
        next_cycle();
        fpm_result_valid = 1'b1; fpm_result = 32'hDEADBEEF;
        sample();
        check("sp_loadb_bus", fpm_number_in, 32'h3E4CCCCD);
        next_cycle();
        fpm_result_valid = 1'b0; fpm_result = '0; fpm_b_ready = 1'b1;
        sample();
        check("sp_still_loadb", 32'({fpm_b_valid, rsp0_valid}), 32'b10);
        next_cycle();
        sample();
        check("sp_wait", 32'({fpm_b_valid, rsp0_valid, busy}), 32'b001);
        next_cycle();
        fpm_result_valid = 1'b1; fpm_result = 32'h3F800000;
        sample();
        next_cycle();
        fpm_result_valid = 1'b0; fpm_result = '0; rsp0_ready = 1'b1;
        sample();
        check("sp_rsp_valid", 32'({rsp0_valid, rsp1_valid, rsp0_err}), 32'b100);
        check("sp_rsp_data", rsp0_data, 32'h3F800000);
        next_cycle();
        rsp0_ready = 1'b0;
        sample();
        check("sp_done", 32'(busy), 32'd0);

        // Reset pulse in WAIT_RES aborts the transaction.
        do_reset();
        next_cycle();
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
        sample();
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        check("rm_wait_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0; req0_valid = 1'b1;
        #1;
        check("rm_async_flags", 32'({req0_ready, req1_ready, busy, fpm_a_valid, fpm_b_valid,
                                    rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
        check("rm_async_bus", fpm_number_in | rsp0_data | rsp1_data, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; rst = 1'b1;
        next_cycle();
        fpm_result_valid = 1'b1; fpm_result = 32'h40800000;
        sample();
        check("rm_pulse_ignored", 32'({busy, rsp0_valid, rsp1_valid}), 32'd0);
        next_cycle();
        fpm_result_valid = 1'b0; fpm_result = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            sample();
            check("rm_stay_idle", 32'({busy, rsp0_valid, rsp1_valid}), 32'd0);
        end

        // Result never arrives.
        do_reset();
        next_cycle();
        req1_valid = 1'b1; req1_a = 32'h40E00000; req1_b = 32'h41000000;
        sample();
        next_cycle();
        req1_valid = 1'b0;
        next_cycle();
        for (int i = 0; i < TO; i++) begin
            next_cycle();
            sample();
            check("to_waiting", 32'({busy, rsp1_valid}), 32'b10);
        end
        next_cycle();
        rsp1_ready = 1'b1;
        sample();
`ifdef FPM_ARB_TIMEOUT_EN
        check("to_rsp_flags", 32'({rsp1_valid, rsp1_err, rsp0_valid}), 32'b110);
        check("to_rsp_data", rsp1_data, 32'h7FC00000);
        next_cycle();
        rsp1_ready = 1'b0;
        sample();
        check("to_done", 32'(busy), 32'd0);
`else
        check("to_no_rsp", 32'({busy, rsp1_valid, rsp1_err}), 32'b100);
        repeat (20) next_cycle();
        sample();
        check("to_still_busy", 32'({busy, rsp1_valid}), 32'b10);
`endif

        do_reset();
        random_run(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
